// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage M-extension sequencer: op encodings,
// FSM states and the default datapath width.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } mdu_state_e;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Radix-2 iterative datapath: unsigned shift-add multiply or restoring divide,
// one step per step_i. {hi,lo} is the 2W accumulator; opb is multiplicand/divisor.
module muldiv_iter_dp #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic         step_i,
   input  logic         div_i,
   input  logic [W-1:0] load_hi_i,
   input  logic [W-1:0] load_lo_i,
   input  logic [W-1:0] load_opb_i,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);

   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;
   logic [W-1:0] opb_q, opb_d;
   logic [W:0]   sum;
   logic [W:0]   shifted;
   logic [W:0]   diff;

   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      shifted = {hi_q, lo_q[W-1]};
      diff    = shifted - {1'b0, opb_q};
      if (clear_i) begin
         hi_d  = '0;
         lo_d  = '0;
         opb_d = '0;
      end else if (load_i) begin
         hi_d  = load_hi_i;
         lo_d  = load_lo_i;
         opb_d = load_opb_i;
      end else if (step_i) begin
         if (div_i) begin
            // Top bit of diff is the borrow: set means the trial subtract is undone.
            if (!diff[W]) begin
               hi_d = diff[W-1:0];
               lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
               hi_d = shifted[W-1:0];
               lo_d = {lo_q[W-2:0], 1'b0};
            end
         end else begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         opb_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         opb_q <= opb_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M sequencer beside the EX ALU: stalls the pipe while the iterative
// datapath runs, handles sign fix-up, divide special cases and flush.
module ex_muldiv_ctrl #(
   parameter int unsigned XLEN  = cpu_pkg::XLEN,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic [XLEN-1:0] result_o,
   output logic            result_valid_o
);
   import cpu_pkg::*;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e      state_q, state_d;
   mdu_op_e         op_q, op_d, op_in;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            dp_clear, dp_load, dp_step, dp_div;
   logic [XLEN-1:0] dp_load_hi, dp_load_lo, dp_load_opb;
   logic [XLEN-1:0] dp_hi, dp_lo;

   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] res_calc;

   assign op_in    = mdu_op_e'(op_i);
   assign a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   assign b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
   assign a_neg    = a_signed & rs1_i[XLEN-1];
   assign b_neg    = b_signed & rs2_i[XLEN-1];
   assign mag_a    = a_neg ? -rs1_i : rs1_i;
   assign mag_b    = b_neg ? -rs2_i : rs2_i;

   always_comb begin
      prod_s = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
      case (op_q)
         OP_MUL:                      res_calc = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res_calc = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             res_calc = neg_q ? -dp_lo : dp_lo;
         default:                     res_calc = neg_q ? -dp_hi : dp_hi;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      cnt_d          = cnt_q;
      neg_d          = neg_q;
      result_d       = result_q;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      dp_clear       = 1'b0;
      dp_load        = 1'b0;
      dp_step        = 1'b0;
      dp_load_hi     = '0;
      dp_load_lo     = '0;
      dp_load_opb    = '0;
      case (state_q)
         ST_IDLE: begin
            if (valid_i && !flush_i) begin
               stall_o = 1'b1;
               op_d    = op_in;
               cnt_d   = CNT_W'(XLEN);
               dp_load = 1'b1;
               neg_d   = (op_in inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
               // Special cases preload the final raw result with no sign fix-up.
               if (op_i[2] && rs2_i == '0) begin
                  dp_load_hi = rs1_i;
                  dp_load_lo = '1;
                  neg_d      = 1'b0;
                  state_d    = ST_DONE;
               end else if ((op_in inside {OP_DIV, OP_REM}) && rs1_i == MIN_NEG && rs2_i == '1) begin
                  dp_load_lo = MIN_NEG;
                  neg_d      = 1'b0;
                  state_d    = ST_DONE;
               end else if (op_i[2]) begin
                  dp_load_lo  = mag_a;
                  dp_load_opb = mag_b;
                  state_d     = ST_DIV;
               end else begin
                  dp_load_lo  = mag_b;
                  dp_load_opb = mag_a;
                  state_d     = ST_MUL;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            stall_o = 1'b1;
            if (flush_i) begin
               dp_clear = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               dp_step = 1'b1;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
         end
         default: begin
            result_valid_o = 1'b1;
            result_d       = res_calc;
            state_d        = ST_IDLE;
         end
      endcase
   end

   assign dp_div   = (state_q == ST_DIV);
   assign busy_o   = (state_q != ST_IDLE);
   assign result_o = (state_q == ST_DONE) ? res_calc : result_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   muldiv_iter_dp #(.W(XLEN)) u_dp (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (dp_clear),
      .load_i     (dp_load),
      .step_i     (dp_step),
      .div_i      (dp_div),
      .load_hi_i  (dp_load_hi),
      .load_lo_i  (dp_load_lo),
      .load_opb_i (dp_load_opb),
      .hi_o       (dp_hi),
      .lo_o       (dp_lo)
   );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl with hand-computed results.
module tb_ex_muldiv_ctrl;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic [31:0] result_o;
   logic        result_valid_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_i        (valid_i),
      .op_i           (op_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .flush_i        (flush_i),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the FSM idle; drives the op and checks the accept cycle.
   task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      valid_i = 1'b1;
      op_i    = op;
      rs1_i   = a;
      rs2_i   = b;
      #1;
      check({tag, "_accept_stall"}, {31'b0, stall_o}, 32'd1);
      check({tag, "_accept_busy"}, {31'b0, busy_o}, 32'd0);
   endtask

   task automatic wait_result(input string tag, input logic [31:0] exp, input int lat,
                              input bit chain, input logic [2:0] op2,
                              input logic [31:0] a2, input logic [31:0] b2);
      int n = 0;
      int stalls = 1;
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         valid_i = 1'b0;
         n++;
         #1;
         if (result_valid_o) seen = 1'b1;
         else if (stall_o) stalls++;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_result"}, result_o, exp);
      check({tag, "_done_stall"}, {31'b0, stall_o}, 32'd0);
      check({tag, "_stall_cycles"}, stalls, lat);
      if (chain) begin
         valid_i = 1'b1;
         op_i    = op2;
         rs1_i   = a2;
         rs2_i   = b2;
         #1;
         check({tag, "_done_ignores_valid"}, {31'b0, stall_o}, 32'd0);
      end
      @(negedge clk);
      #1;
      check({tag, "_valid_one_cycle"}, {31'b0, result_valid_o}, 32'd0);
      check({tag, "_idle_after"}, {31'b0, busy_o}, 32'd0);
      if (chain) check({tag, "_next_accepted"}, {31'b0, stall_o}, 32'd1);
   endtask

   initial begin
      int spurious;
      rst_n   = 1'b0;
      valid_i = 1'b0;
      op_i    = 3'd0;
      rs1_i   = '0;
      rs2_i   = '0;
      flush_i = 1'b0;
      #12;
      check("rst_stall", {31'b0, stall_o}, 32'd0);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_valid", {31'b0, result_valid_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD);
      wait_result("mul", 32'hFFFF_FFEB, 33, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000);
      wait_result("mulh", 32'h4000_0000, 33, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result("mulhu", 32'hFFFF_FFFE, 33, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
      wait_result("mulhsu", 32'hFFFF_FFFF, 33, 1'b0, 3'd0, 32'd0, 32'd0);

      issue("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_result("div", 32'hFFFF_FFFD, 33, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("rem", OP_REM, 32'hFFFF_FFF9, 32'd2);
      wait_result("rem", 32'hFFFF_FFFF, 33, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("divu", OP_DIVU, 32'd100, 32'd7);
      wait_result("divu", 32'd14, 33, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("remu", OP_REMU, 32'd100, 32'd7);
      wait_result("remu", 32'd2, 33, 1'b0, 3'd0, 32'd0, 32'd0);

      issue("divu_by0", OP_DIVU, 32'd5, 32'd0);
      wait_result("divu_by0", 32'hFFFF_FFFF, 1, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("rem_by0", OP_REM, 32'd5, 32'd0);
      wait_result("rem_by0", 32'd5, 1, 1'b0, 3'd0, 32'd0, 32'd0);
      issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("div_ovf", 32'h8000_0000, 1, 1'b0, 3'd0, 32'd0, 32'd0);

      issue("flush", OP_DIV, 32'd1000, 32'd3);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         valid_i = 1'b0;
      end
      flush_i = 1'b1;
      #1;
      check("flush_cycle_stall", {31'b0, stall_o}, 32'd1);
      check("flush_cycle_busy", {31'b0, busy_o}, 32'd1);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      check("flush_stall_drop", {31'b0, stall_o}, 32'd0);
      check("flush_busy_drop", {31'b0, busy_o}, 32'd0);
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         if (result_valid_o) spurious++;
         @(negedge clk);
      end
      check("flush_no_result", spurious, 0);
      issue("mul_after_flush", OP_MUL, 32'd3, 32'd4);
      wait_result("mul_after_flush", 32'd12, 33, 1'b0, 3'd0, 32'd0, 32'd0);

      issue("b2b_mul", OP_MUL, 32'd6, 32'd9);
      wait_result("b2b_mul", 32'd54, 33, 1'b1, OP_DIVU, 32'd1000, 32'd9);
      wait_result("b2b_divu", 32'd111, 33, 1'b0, 3'd0, 32'd0, 32'd0);

      issue("rst_mid", OP_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         valid_i = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("rst_mid_stall", {31'b0, stall_o}, 32'd0);
      check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
      check("rst_mid_result", result_o, 32'd0);
      check("rst_mid_valid", {31'b0, result_valid_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("rst_rel_busy", {31'b0, busy_o}, 32'd0);
      check("rst_rel_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      issue("remu_after_rst", OP_REMU, 32'd100, 32'd7);
      wait_result("remu_after_rst", 32'd2, 33, 1'b0, 3'd0, 32'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
